// File: rtl/intr_sequencer.sv
// Interrupt entry / HLT / RTI sequencer: drains the pipeline, pushes the resume PC,
// fetches the interrupt vector and restores flags on RTI. Outputs are registered.
module intr_sequencer #(
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [7:0]  VEC_ADDR     = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       intr_flag,
    input  logic       hlt_req,
    input  logic       rti_req,
    input  logic [7:0] pc_next,
    input  logic [7:0] sp,
    input  logic [3:0] flags_in,
    input  logic [7:0] mem_rdata,
    output logic       inter_en,
    output logic       intr_clear,
    output logic       hlt_en,
    output logic       stall,
    output logic       busy,
    output logic       mem_we,
    output logic       mem_re,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       sp_dec,
    output logic       pc_load,
    output logic [7:0] pc_load_val,
    output logic       flags_restore,
    output logic [3:0] flags_out
);

    typedef enum logic [2:0] {
        IDLE, HALT, DRAIN, PUSH, VEC_RD, VEC_LD, RTI_R
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] shadow_q, shadow_d;

    logic       inter_en_q, inter_en_d;
    logic       intr_clear_q, intr_clear_d;
    logic       hlt_en_q, hlt_en_d;
    logic       stall_q, stall_d;
    logic       busy_q, busy_d;
    logic       mem_we_q, mem_we_d;
    logic       mem_re_q, mem_re_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_wdata_q, mem_wdata_d;
    logic       sp_dec_q, sp_dec_d;
    logic       pc_load_q, pc_load_d;
    logic       flags_restore_q, flags_restore_d;
    logic [3:0] flags_out_q, flags_out_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        unique case (state_q)
            IDLE: begin
                if (intr_flag) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end else if (hlt_req) begin
                    state_d = HALT;
                end else if (rti_req) begin
                    state_d = RTI_R;
                end
            end
            HALT: begin
                if (intr_flag) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (cnt_q == 4'd0) state_d = PUSH;
                else               cnt_d   = cnt_q - 4'd1;
            end
            PUSH: begin
                state_d  = VEC_RD;
                shadow_d = flags_in;
            end
            VEC_RD:  state_d = VEC_LD;
            VEC_LD:  state_d = IDLE;
            RTI_R:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they appear registered in that state.
    // SP and PC are frozen by stall, so sampling them on the edge into PUSH is safe.
    always_comb begin
        inter_en_d      = (state_d == IDLE) || (state_d == HALT);
        stall_d         = (state_d != IDLE) && (state_d != RTI_R);
        busy_d          = (state_d != IDLE);
        hlt_en_d        = (state_q == IDLE) && (state_d == HALT);
        mem_we_d        = (state_d == PUSH);
        sp_dec_d        = (state_d == PUSH);
        intr_clear_d    = (state_d == PUSH);
        mem_re_d        = (state_d == VEC_RD);
        pc_load_d       = (state_d == VEC_LD);
        flags_restore_d = (state_d == RTI_R);
        mem_addr_d      = 8'h00;
        if (state_d == PUSH)        mem_addr_d = sp;
        else if (state_d == VEC_RD) mem_addr_d = VEC_ADDR;
        mem_wdata_d     = (state_d == PUSH)  ? pc_next  : 8'h00;
        flags_out_d     = (state_d == RTI_R) ? shadow_q : 4'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            cnt_q           <= 4'd0;
            shadow_q        <= 4'h0;
            inter_en_q      <= 1'b1;
            intr_clear_q    <= 1'b0;
            hlt_en_q        <= 1'b0;
            stall_q         <= 1'b0;
            busy_q          <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_re_q        <= 1'b0;
            mem_addr_q      <= 8'h00;
            mem_wdata_q     <= 8'h00;
            sp_dec_q        <= 1'b0;
            pc_load_q       <= 1'b0;
            flags_restore_q <= 1'b0;
            flags_out_q     <= 4'h0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            shadow_q        <= shadow_d;
            inter_en_q      <= inter_en_d;
            intr_clear_q    <= intr_clear_d;
            hlt_en_q        <= hlt_en_d;
            stall_q         <= stall_d;
            busy_q          <= busy_d;
            mem_we_q        <= mem_we_d;
            mem_re_q        <= mem_re_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            sp_dec_q        <= sp_dec_d;
            pc_load_q       <= pc_load_d;
            flags_restore_q <= flags_restore_d;
            flags_out_q     <= flags_out_d;
        end
    end

    assign inter_en      = inter_en_q;
    assign intr_clear    = intr_clear_q;
    assign hlt_en        = hlt_en_q;
    assign stall         = stall_q;
    assign busy          = busy_q;
    assign mem_we        = mem_we_q;
    assign mem_re        = mem_re_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign sp_dec        = sp_dec_q;
    assign pc_load       = pc_load_q;
    assign flags_restore = flags_restore_q;
    assign flags_out     = flags_out_q;
    // Vector data arrives the cycle after the read, so it is forwarded straight through.
    assign pc_load_val   = pc_load_q ? mem_rdata : 8'h00;

endmodule

// File: doc/intr_sequencer.md
INTR_SEQUENCER -- requirements
Module: intr_sequencer

Interface
REQ-001 Parameter: DRAIN_CYCLES, default 3, number of pipeline-drain cycles before the context push (legal range 1..15).
REQ-002 Parameter: VEC_ADDR, default 8'h01, data-memory address holding the interrupt vector.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 intr_flag  input  1  latched pending interrupt from the I/O/interrupt block.
REQ-006 hlt_req  input  1  decoded HLT instruction at the decode stage.
REQ-007 rti_req  input  1  decoded RTI instruction at the decode stage.
REQ-008 pc_next  input  8  resume address, meaning the PC of the next unexecuted instruction.
REQ-009 sp  input  8  current stack pointer.
REQ-010 flags_in  input  4  current CCR flags (Z,N,C,V).
REQ-011 mem_rdata  input  8  data-memory read data, valid the cycle after mem_re.
REQ-012 inter_en  output  1  permits intr_flag latching.
REQ-013 intr_clear  output  1  one-cycle pulse that clears intr_flag.
REQ-014 hlt_en  output  1  one-cycle pulse that raises HLT_flag.
REQ-015 stall  output  1  freezes fetch/decode and inserts bubbles.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 mem_we, mem_re  output  1 each  data-memory write/read strobes.
REQ-018 mem_addr, mem_wdata  output  8 each  data-memory address and write data.
REQ-019 sp_dec  output  1  one-cycle pulse that decrements SP.
REQ-020 pc_load  output  1, pc_load_val  output  8  PC override strobe and value.
REQ-021 flags_restore  output  1, flags_out  output  4  CCR restore strobe and value.

Function
REQ-022 The FSM SHALL have the states IDLE, HALT, DRAIN, PUSH, VEC_RD, VEC_LD, RTI_R.
REQ-023 From IDLE, priority SHALL be intr_flag > hlt_req > rti_req; a lower-priority request arriving simultaneously SHALL be ignored and is not queued.
REQ-024 IDLE & intr_flag SHALL go to DRAIN and load drain counter = DRAIN_CYCLES-1.
REQ-025 DRAIN SHALL decrement the counter each cycle and go to PUSH the cycle after the counter reaches 0, so DRAIN lasts exactly DRAIN_CYCLES cycles.
REQ-026 PUSH SHALL assert mem_we=1, mem_addr=sp, mem_wdata=pc_next, sp_dec=1 and intr_clear=1, latch flags_in into an internal 4-bit shadow register, and go to VEC_RD.
REQ-027 VEC_RD SHALL assert mem_re=1 with mem_addr=VEC_ADDR, and go to VEC_LD.
REQ-028 VEC_LD SHALL assert pc_load=1 with pc_load_val=mem_rdata (the only input-to-output combinational path), and go to IDLE.
REQ-029 IDLE & hlt_req & !intr_flag SHALL go to HALT and assert hlt_en for exactly the first HALT cycle.
REQ-030 HALT & intr_flag SHALL go to DRAIN; otherwise the FSM SHALL remain in HALT indefinitely, and only rst exits HALT without an interrupt.
REQ-031 IDLE & rti_req & !intr_flag & !hlt_req SHALL go to RTI_R, which asserts flags_restore=1 with flags_out=shadow for one cycle and then returns to IDLE.
REQ-032 inter_en SHALL be 1 in IDLE and HALT and 0 in all other states, so no nesting occurs.
REQ-033 stall SHALL be 1 in HALT, DRAIN, PUSH, VEC_RD and VEC_LD, and 0 in IDLE and RTI_R.
REQ-034 All outputs except pc_load_val SHALL be decoded from state and registers only.
REQ-035 Inactive strobes SHALL be 0, and mem_addr, mem_wdata, pc_load_val and flags_out SHALL be 0 when their strobe is low.
REQ-036 Interrupt entry latency SHALL be DRAIN_CYCLES+3 cycles from IDLE to the pc_load cycle, inclusive of VEC_LD (default 6).
REQ-037 SP wrap-around is the SP owner's concern; sp=8'h00 SHALL be pushed to address 8'h00 unmodified.
REQ-038 intr_flag re-asserting during DRAIN, VEC_RD or VEC_LD SHALL be serviced only after returning to IDLE.

Reset
REQ-039 rst low SHALL force IDLE at any time, including mid-sequence, with no further memory strobes.
REQ-040 During reset, drain counter=0 and shadow=4'b0.
REQ-041 During reset, all outputs SHALL be 0 except inter_en=1.

Verification
REQ-042 Entry: rst released, sp=8'hFF, pc_next=8'h23, flags_in=4'b1010, M[1]=8'h40, intr_flag pulses at cycle 0 -> stall cycles 1-6; PUSH at cycle 4 writes 8'h23 to 8'hFF with sp_dec=1 and intr_clear=1; pc_load at cycle 6 with value 8'h40; busy=0 at cycle 7.
REQ-043 HLT wake: hlt_req for 1 cycle -> hlt_en pulses once and stall stays high; after 20 idle cycles, intr_flag=1 -> DRAIN then full entry sequence.
REQ-044 Simultaneous: intr_flag=1, hlt_req=1, rti_req=1 in IDLE -> interrupt sequence only; hlt_en=0 and flags_restore=0 throughout.
REQ-045 RTI after entry: rti_req in IDLE -> flags_restore=1 for one cycle with flags_out=4'b1010.
REQ-046 Reset mid-op: rst low during VEC_RD -> immediately state=IDLE, mem_re=0, stall=0, inter_en=1; after release, flags_out is 0 on the next RTI.
REQ-047 Parameter sweep: DRAIN_CYCLES=1 and DRAIN_CYCLES=15 -> entry latency of 4 and 18 cycles respectively.
